nios_sysid_checker: RTL and testbench

Avalon-MM read master that sits opposite the system-ID slave and confirms the hardware build matches the software image. After reset (or on a `start` pulse) it reads the ID word (address 0) and the timestamp word (address 1). It compares both against build-time parameters and reports match, timeout and the captured values to the boot or status logic. It supports `waitrequest` stalls and variable read latency via `readdatavalid`, and bounds every wait with a timeout.

---
 rtl/nios_sysid_checker.sv | 141 ++++++++++++++
 tb/tb_nios_sysid_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sysid_checker.sv
// System-ID checker: reads the ID and timestamp words over Avalon-MM and
// compares them against build-time constants, bounding every wait with a timeout.
module nios_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1461568625,
   parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_boot;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            r_busy, r_done, r_id_match, r_ts_match, r_timeout;
   logic [DW-1:0]   r_id_value, r_ts_value;
   logic            w_busy_n, w_done_n, w_id_match_n, w_ts_match_n, w_timeout_n;
   logic [DW-1:0]   w_id_value_n, w_ts_value_n;
   logic            w_active;
   logic            w_limit;

   // Next-state, capture and timeout decisions
   always_comb begin
      w_next       = r_state;
      w_id_match_n = r_id_match;
      w_ts_match_n = r_ts_match;
      w_timeout_n  = r_timeout;
      w_id_value_n = r_id_value;
      w_ts_value_n = r_ts_value;
      w_active     = (r_state == S_RD_ID) || (r_state == S_WAIT_ID) ||
                     (r_state == S_RD_TS) || (r_state == S_WAIT_TS);
      w_limit      = (r_cnt == (TIMEOUT_CYCLES - 16'd1));
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start || r_boot) begin
               w_next       = S_RD_ID;
               w_id_match_n = 1'b0;
               w_ts_match_n = 1'b0;
               w_timeout_n  = 1'b0;
               w_id_value_n = '0;
               w_ts_value_n = '0;
            end
         end
         S_RD_ID, S_RD_TS: begin
            if (!avm_waitrequest) begin
               w_next = (r_state == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
            end else if (w_limit) begin
               w_next      = S_DONE;
               w_timeout_n = 1'b1;
            end
         end
         S_WAIT_ID: begin
            if (avm_readdatavalid) begin
               w_next       = S_RD_TS;
               w_id_value_n = avm_readdata;
               w_id_match_n = (avm_readdata == EXPECTED_ID);
            end else if (w_limit) begin
               w_next      = S_DONE;
               w_timeout_n = 1'b1;
            end
         end
         S_WAIT_TS: begin
            if (avm_readdatavalid) begin
               w_next       = S_DONE;
               w_ts_value_n = avm_readdata;
               w_ts_match_n = (avm_readdata == EXPECTED_TIMESTAMP);
            end else if (w_limit) begin
               w_next      = S_DONE;
               w_timeout_n = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // A state change always restarts the per-state timeout window
      w_cnt_next = ((w_next != r_state) || !w_active) ? '0 : r_cnt + 16'd1;
      w_busy_n   = (w_next == S_RD_ID) || (w_next == S_WAIT_ID) ||
                   (w_next == S_RD_TS) || (w_next == S_WAIT_TS);
      w_done_n   = (r_state == S_DONE) && (w_next == S_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_boot     <= AUTO_START;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_id_match <= 1'b0;
         r_ts_match <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= '0;
         r_ts_value <= '0;
      end else begin
         r_state    <= w_next;
         r_boot     <= 1'b0;
         r_cnt      <= w_cnt_next;
         r_busy     <= w_busy_n;
         r_done     <= w_done_n;
         r_id_match <= w_id_match_n;
         r_ts_match <= w_ts_match_n;
         r_timeout  <= w_timeout_n;
         r_id_value <= w_id_value_n;
         r_ts_value <= w_ts_value_n;
      end
   end

   // Bus request decodes straight from the state so reset drops it at once
   assign avm_read    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
   assign avm_address = (r_state == S_RD_TS) || (r_state == S_WAIT_TS);
   assign busy        = r_busy;
   assign done        = r_done;
   assign id_match    = r_id_match;
   assign ts_match    = r_ts_match;
   assign timeout     = r_timeout;
   assign id_value    = r_id_value;
   assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Bench for nios_sysid_checker: scripted Avalon slaves, a timeline model for
// the auto-start instance, and directed reset/idle checks on a manual-start instance.
`timescale 1ns/1ps
module tb_nios_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1461568625;
   localparam int T = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic        rst_a, start_a, wr_a, rdv_a;
   logic [31:0] rdata_a;
   logic        addr_a, read_a, busy_a, done_a, idm_a, tsm_a, tmo_a;
   logic [31:0] idv_a, tsv_a;

   logic        rst_b, start_b, wr_b, rdv_b;
   logic [31:0] rdata_b;
   logic        addr_b, read_b, busy_b, done_b, idm_b, tsm_b, tmo_b;
   logic [31:0] idv_b, tsv_b;

   nios_sysid_checker #(.TIMEOUT_CYCLES(16'd8), .AUTO_START(1'b1)) u_a (
      .clock(clk), .reset(rst_a), .start(start_a),
      .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a),
      .avm_readdata(rdata_a), .avm_readdatavalid(rdv_a),
      .busy(busy_a), .done(done_a), .id_match(idm_a), .ts_match(tsm_a),
      .timeout(tmo_a), .id_value(idv_a), .ts_value(tsv_a));

   nios_sysid_checker #(.AUTO_START(1'b0)) u_b (
      .clock(clk), .reset(rst_b), .start(start_b),
      .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wr_b),
      .avm_readdata(rdata_b), .avm_readdatavalid(rdv_b),
      .busy(busy_b), .done(done_b), .id_match(idm_b), .ts_match(tsm_b),
      .timeout(tmo_b), .id_value(idv_b), .ts_value(tsv_b));

   task automatic chk1(input string nm, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: actual %b required %b", nm, cyc, act, req);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: actual %h required %h", nm, cyc, act, req);
      end
   endtask

   // Scenario for instance A: stall cycles and latency per read, data, ts no-response
   int          sc_s = 1 << 30;
   int          sc_w = 0;
   int          sc_l = 1;
   logic [31:0] sc_d0 = EXP_ID;
   logic [31:0] sc_d1 = EXP_TS;
   bit          sc_noresp = 1'b0;

   typedef struct {
      bit rd; bit ad; bit bsy; bit dn; bit idm; bit tsm; bit tmo;
      logic [31:0] idv; logic [31:0] tsv;
   } exp_t;
   exp_t prev;
   exp_t ex;

   // Expected outputs after edge n, from the start edge and per-read timeline arithmetic
   function automatic exp_t expect_at(input int n);
      exp_t x;
      int   e, a, fin, c0, c1;
      int   lo[2];
      int   hi[2];
      bit   tmo, alive, got0, got1;
      x = prev;
      x.rd = 1'b0; x.ad = 1'b0; x.bsy = 1'b0;
      if (n < sc_s) return x;
      lo = '{1, 1}; hi = '{0, 0};
      c0 = 0; c1 = 0; fin = 0; a = 0;
      tmo = 1'b0; alive = 1'b1; got0 = 1'b0; got1 = 1'b0;
      e = sc_s;
      for (int i = 0; i < 2; i++) begin
         if (alive) begin
            if (sc_w >= T) begin
               lo[i] = e; hi[i] = e + T - 1; fin = e + T; tmo = 1'b1; alive = 1'b0;
            end else begin
               a = e + 1 + sc_w; lo[i] = e; hi[i] = a - 1;
               if ((i == 1 && sc_noresp) || sc_l > T) begin
                  fin = a + T; tmo = 1'b1; alive = 1'b0;
               end else if (i == 0) begin
                  c0 = a + sc_l; got0 = 1'b1; e = c0;
               end else begin
                  c1 = a + sc_l; got1 = 1'b1; fin = c1;
               end
            end
         end
      end
      x.rd  = (n >= lo[0] && n <= hi[0]) || (n >= lo[1] && n <= hi[1]);
      x.ad  = (n >= lo[1] && n <= hi[1]);
      x.bsy = (n < fin);
      x.dn  = (n >= fin + 1);
      x.tmo = tmo && (n >= fin);
      x.idv = (got0 && n >= c0) ? sc_d0 : 32'd0;
      x.idm = got0 && (n >= c0) && (sc_d0 == EXP_ID);
      x.tsv = (got1 && n >= c1) ? sc_d1 : 32'd0;
      x.tsm = got1 && (n >= c1) && (sc_d1 == EXP_TS);
      return x;
   endfunction

   // Per-cycle compare of instance A against the model
   always @(negedge clk) begin
      if (rst_a) begin
         chk1("a_rst_read", read_a, 1'b0);
         chk1("a_rst_busy", busy_a, 1'b0);
         chk1("a_rst_done", done_a, 1'b0);
         chk1("a_rst_tmo", tmo_a, 1'b0);
         chk32("a_rst_idv", idv_a, 32'd0);
         chk32("a_rst_tsv", tsv_a, 32'd0);
      end else begin
         ex = expect_at(cyc);
         chk1("a_avm_read", read_a, ex.rd);
         if (ex.rd) chk1("a_avm_address", addr_a, ex.ad);
         chk1("a_busy", busy_a, ex.bsy);
         chk1("a_done", done_a, ex.dn);
         chk1("a_timeout", tmo_a, ex.tmo);
         chk1("a_id_match", idm_a, ex.idm);
         chk1("a_ts_match", tsm_a, ex.tsm);
         chk32("a_id_value", idv_a, ex.idv);
         chk32("a_ts_value", tsv_a, ex.tsv);
      end
   end

   // Slave A: scripted waitrequest stalls, fixed latency, optional injected stray response
   int          st_cnt = 0;
   int          pend = 0;
   logic [31:0] pdata = '0;
   bit          s_acc, s_stall, s_rd, s_ad;
   int          inj_req = 0;
   int          inj_ack = 0;
   initial begin
      wr_a = 1'b0; rdv_a = 1'b0; rdata_a = '0;
      forever begin
         @(negedge clk);
         s_rd = read_a; s_acc = read_a && !wr_a; s_stall = read_a && wr_a; s_ad = addr_a;
         @(posedge clk); #1;
         rdv_a = 1'b0;
         if (s_acc) begin
            pend  = (s_ad && sc_noresp) ? 0 : sc_l;
            pdata = s_ad ? sc_d1 : sc_d0;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin rdv_a = 1'b1; rdata_a = pdata; end
         end
         if (inj_req != inj_ack) begin
            inj_ack = inj_req; rdv_a = 1'b1; rdata_a = EXP_TS;
         end
         if (s_acc || !s_rd) st_cnt = 0;
         else if (s_stall) st_cnt++;
         wr_a = (st_cnt < sc_w);
      end
   end

   // Slave B: zero-wait, one-cycle latency, always correct data
   bit b_acc, b_ad;
   initial begin
      rdv_b = 1'b0; rdata_b = '0;
      forever begin
         @(negedge clk);
         b_acc = read_b && !wr_b; b_ad = addr_b;
         @(posedge clk); #1;
         rdv_b = b_acc;
         rdata_b = b_ad ? EXP_TS : EXP_ID;
      end
   end

   task automatic wait_done_a(input int budget, output int dn_edge);
      dn_edge = -1;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #2;
         if (done_a) begin dn_edge = cyc; break; end
      end
      if (dn_edge < 0) begin
         n_checks++; n_fail++;
         $display("FAIL a_wait_done @cycle %0d: done not seen within %0d cycles", cyc, budget);
      end
   endtask

   task automatic run_a(input int w, input int l, input logic [31:0] d0, input logic [31:0] d1,
                        input bit nr, input bit extra_start, output int lat);
      int dn;
      @(posedge clk); #2;
      prev  = expect_at(cyc);
      sc_w  = w; sc_l = l; sc_d0 = d0; sc_d1 = d1; sc_noresp = nr;
      sc_s  = cyc + 1;
      start_a = 1'b1;
      @(posedge clk); #2;
      start_a = 1'b0;
      chk1("a_start_clears_done", done_a, 1'b0);
      chk1("a_start_clears_tmo", tmo_a, 1'b0);
      if (extra_start) begin
         @(posedge clk); #2; start_a = 1'b1;
         @(posedge clk); #2; start_a = 1'b0;
      end
      wait_done_a(100, dn);
      lat = dn - sc_s;
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic run_b(output int lat);
      int s, dn;
      dn = -1;
      @(posedge clk); #2;
      s = cyc + 1; start_b = 1'b1;
      @(posedge clk); #2; start_b = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #2;
         if (done_b) begin dn = cyc; break; end
      end
      if (dn < 0) begin
         n_checks++; n_fail++;
         $display("FAIL b_wait_done @cycle %0d: done not seen within 50 cycles", cyc);
      end
      lat = dn - s;
   endtask

   task automatic b_idle_window(input string nm);
      repeat (8) begin
         @(posedge clk); #2;
         chk1(nm, read_b || busy_b || done_b, 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog @cycle %0d: simulation did not finish", cyc);
      $fatal(1);
   end

   int lat;
   initial begin
      prev = '{default: '0};
      rst_a = 1'b1; start_a = 1'b0;
      rst_b = 1'b1; start_b = 1'b0; wr_b = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_a = 1'b0;
      sc_s  = cyc + 1;
      wait_done_a(50, lat);
      chk32("a1_auto_done_latency", 32'(lat - sc_s), 32'd5);
      chk32("a1_id_value", idv_a, 32'd0);
      chk32("a1_ts_value", tsv_a, 32'd1461568625);
      chk1("a1_id_match", idm_a, 1'b1);
      chk1("a1_ts_match", tsm_a, 1'b1);
      chk1("a1_timeout", tmo_a, 1'b0);
      repeat (2) @(posedge clk);

      run_a(3, 4, EXP_ID, EXP_TS, 1'b0, 1'b1, lat);
      chk1("a2_stall_id_match", idm_a, 1'b1);
      chk1("a2_stall_ts_match", tsm_a, 1'b1);

      run_a(0, 1, EXP_ID, 32'h12345678, 1'b0, 1'b0, lat);
      chk1("a3_bad_ts_match", tsm_a, 1'b0);
      chk1("a3_id_match", idm_a, 1'b1);
      chk32("a3_ts_value", tsv_a, 32'h12345678);
      chk1("a3_timeout", tmo_a, 1'b0);

      run_a(0, 1, EXP_ID, EXP_TS, 1'b1, 1'b0, lat);
      chk32("a4_timeout_done_latency", 32'(lat), 32'd12);
      chk1("a4_timeout", tmo_a, 1'b1);
      chk1("a4_ts_match", tsm_a, 1'b0);
      chk32("a4_ts_value", tsv_a, 32'd0);
      chk1("a4_id_match", idm_a, 1'b1);
      inj_req++;
      repeat (3) @(posedge clk);
      #2;
      chk32("a4_late_rdv_ignored", tsv_a, 32'd0);
      chk1("a4_late_rdv_done_held", done_a, 1'b1);

      run_a(1, 2, EXP_ID, EXP_TS, 1'b0, 1'b0, lat);
      chk1("a5_recheck_id_match", idm_a, 1'b1);
      chk1("a5_recheck_ts_match", tsm_a, 1'b1);

      run_a(7, 8, EXP_ID, EXP_TS, 1'b0, 1'b0, lat);
      chk1("a6_limit_priority_tmo", tmo_a, 1'b0);
      chk1("a6_limit_priority_ts", tsm_a, 1'b1);

      run_a(8, 1, EXP_ID, EXP_TS, 1'b0, 1'b0, lat);
      chk32("a7_rd_timeout_latency", 32'(lat), 32'd9);
      chk1("a7_rd_timeout", tmo_a, 1'b1);
      chk1("a7_id_match", idm_a, 1'b0);

      run_a(0, 9, EXP_ID, EXP_TS, 1'b0, 1'b0, lat);
      chk1("a8_wait_timeout", tmo_a, 1'b1);
      chk32("a8_id_value", idv_a, 32'd0);

      run_a(0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0, lat);
      chk32("a9_final_latency", 32'(lat), 32'd5);

      chk1("b_rst_busy", busy_b, 1'b0);
      chk1("b_rst_done", done_b, 1'b0);
      rst_b = 1'b0;
      b_idle_window("b_no_autostart");
      run_b(lat);
      chk32("b_manual_latency", 32'(lat), 32'd5);
      chk1("b_id_match", idm_b, 1'b1);
      chk1("b_ts_match", tsm_b, 1'b1);
      chk32("b_ts_value", tsv_b, EXP_TS);

      wr_b = 1'b1;
      @(posedge clk); #2; start_b = 1'b1;
      @(posedge clk); #2; start_b = 1'b0;
      chk1("b_rd_stalled_read", read_b, 1'b1);
      #1 rst_b = 1'b1;
      #1;
      chk1("b_rst_rd_read", read_b, 1'b0);
      chk1("b_rst_rd_busy", busy_b, 1'b0);
      chk1("b_rst_rd_done", done_b, 1'b0);
      chk32("b_rst_rd_tsv", tsv_b, 32'd0);
      @(posedge clk); #2; rst_b = 1'b0; wr_b = 1'b0;
      b_idle_window("b_idle_after_rd_reset");

      @(posedge clk); #2; start_b = 1'b1;
      @(posedge clk); #2; start_b = 1'b0;
      @(posedge clk); #2;
      chk1("b_wait_id_busy", busy_b, 1'b1);
      chk1("b_wait_id_read", read_b, 1'b0);
      #1 rst_b = 1'b1;
      #1;
      chk1("b_rst_wait_busy", busy_b, 1'b0);
      chk1("b_rst_wait_done", done_b, 1'b0);
      chk1("b_rst_wait_read", read_b, 1'b0);
      @(posedge clk); #2; rst_b = 1'b0;
      b_idle_window("b_idle_after_wait_reset");
      run_b(lat);
      chk32("b_after_reset_latency", 32'(lat), 32'd5);
      chk1("b_after_reset_match", idm_b && tsm_b, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
